tdc_meas_seq: RTL and testbench
===============================

# tdc_meas_seq

Measurement sequencer on the driving side of the dual-TDC multiplexer. On each accepted request it selects a TDC (ping-pong between TDC 0 and TDC 1), issues one `start` pulse and one `stop` pulse a programmed number of cycles apart, and waits for the selected TDC's `trigger` (conversion done) with a timeout. The result is reported as a one-cycle `done` strobe with status. It feeds `start`, `stop` and `cntrl_tdc` into the mux and consumes the muxed `trigger`.

## Interface
- `CNT_W`, 8: width of the start-to-stop delay operand.
- `TIMEOUT`, 1000: maximum cycles spent in WAIT_TRIG before a timeout is declared; must be ≥ 1.
- `PINGPONG`, 1: 1 = alternate TDCs after each successful measurement; 0 = always TDC 0.
- `clk`  in  1  system clock; the single clock of the block.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  measurement request; sampled only in IDLE.
- `delay`  in  CNT_W  start-to-stop gap D; latched with `req`.
- `trigger`  in  1  muxed TDC done; asynchronous to `clk`.
- `start`  out  1  start pulse to the mux.
- `stop`  out  1  stop pulse to the mux.
- `cntrl_tdc`  out  1  TDC select to the mux; 0 = TDC 0, 1 = TDC 1.
- `busy`  out  1  high from request acceptance until the done cycle, inclusive.
- `done`  out  1  one-cycle result strobe.
- `timeout`  out  1  valid with `done`; 1 = no trigger within TIMEOUT.
- `tdc_id`  out  1  valid with `done`; the TDC used for this measurement.
- `meas_cnt`  out  16  count of successful measurements; wraps from 0xFFFF to 0x0000.

## Operation
- State machine: IDLE → ARM → START → GAP → STOP → WAIT_TRIG → DONE → IDLE.
- IDLE: when `req`=1, latch `delay` and go to ARM. `req` in any other state is ignored; requests are not queued.
- ARM: one settle cycle. `cntrl_tdc` is already stable here and stays stable until DONE exits.
- START: `start`=1 for exactly one cycle.
- GAP: hold for D cycles (down-counter). D=0 skips GAP.
- STOP: `stop`=1 for exactly one cycle. Then clear the timeout counter.
- WAIT_TRIG: `trigger` passes a 2-FF synchronizer and a rising-edge detector.
  - On a detected edge, go to DONE with timeout=0.
  - After TIMEOUT cycles with no edge, go to DONE with timeout=1.
  - If an edge and expiry coincide, success wins.
  - Edges detected outside WAIT_TRIG are discarded. A level already high at WAIT_TRIG entry is not an edge.
- DONE: for one cycle, `done`=1, `tdc_id`=`cntrl_tdc`, and `timeout` as resolved.
  - On success, `meas_cnt`+1, and `cntrl_tdc` toggles on exit if PINGPONG=1.
  - On timeout, `cntrl_tdc` is unchanged.
- `start` and `stop` are never high together, and `cntrl_tdc` never changes in a cycle where either is high.
- Reset values: state IDLE; every output 0 (`start`, `stop`, `cntrl_tdc`, `busy`, `done`, `timeout`, `tdc_id`, `meas_cnt`); synchronizer and edge flops 0.
- Reset mid-operation: at the next edge all outputs return to reset values, and any `start`/`stop` pulse in flight is truncated. No done strobe is issued.

## Timing
- `req` sampled in cycle N gives:
  - `busy`=1 and ARM in N+1;
  - `start`=1 in N+2;
  - `stop`=1 in N+3+D.
- `trigger` rising before clock edge T is detected at T+2 (synchronizer). `done` is asserted in the following cycle, T+3.
- Timeout: `done` in cycle S+TIMEOUT+2, where S is the STOP cycle.
- `busy` falls in the cycle after DONE, when IDLE is reached. Earliest accepted follow-on `req` is sampled in that IDLE cycle.
- Minimum request-to-request spacing: 6 + D + trigger latency cycles.

## Structure
- Shared package `tdc_pkg` holds:
  - the state enum `tdc_seq_state_t` (7 states);
  - the select localparams `TDC_A`=1'b0 and `TDC_B`=1'b1;
  - `MEAS_CNT_W`=16.
- Sub-module `trig_sync_edge` contains the 2-FF synchronizer plus the rising-edge pulse, with synchronous reset.
- The FSM, delay counter, timeout counter and `meas_cnt` sit in the top level.

## Test plan
- Reset, then `req`=1 with `delay`=5 → `start` in cycle 2 after `req`, `stop` in cycle 8; `cntrl_tdc`=0 throughout.
- `trigger` rises 10 cycles after `stop` → `done`=1, `timeout`=0, `tdc_id`=0, `meas_cnt`=1. Next measurement uses `cntrl_tdc`=1; a third uses 0 again.
- TIMEOUT=20, no `trigger` → `done` exactly 22 cycles after the STOP cycle with `timeout`=1; `cntrl_tdc` unchanged; `meas_cnt` unchanged.
- `trigger` held high from reset, or pulsed during GAP → no done until a fresh rising edge in WAIT_TRIG. `req` pulsed while `busy` → ignored.
- `delay`=0 → `stop` in the cycle directly after `start`. PINGPONG=0 → `cntrl_tdc` stays 0 over 4 measurements.
- `rst` asserted during GAP, then during the `start` cycle → all outputs 0 next cycle, no `done`. `meas_cnt` preloaded to 0xFFFF by 65535 forced successes → wraps to 0x0000.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types for the TDC measurement sequencer.
// State encoding, TDC select values and the counter width.
package tdc_pkg;

  localparam int MEAS_CNT_W = 16;

  localparam logic TDC_A = 1'b0;
  localparam logic TDC_B = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_GAP,
    S_STOP,
    S_WAIT_TRIG,
    S_DONE
  } tdc_seq_state_t;

  // Select for the next measurement after a success.
  function automatic logic next_tdc(
    input logic cur,
    input bit   pp
  );
    return pp ? ~cur : TDC_A;
  endfunction

endpackage

// File: rtl/tdc_meas_seq_if.sv
// Request/result and TDC-mux bundle of the measurement sequencer.
// master drives requests and trigger; slave is the sequencer.
interface tdc_meas_seq_if #(
  parameter int CNT_W = 8
);
  import tdc_pkg::*;

  logic                  req;
  logic [CNT_W-1:0]      delay;
  logic                  trigger;
  logic                  start;
  logic                  stop;
  logic                  cntrl_tdc;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic                  tdc_id;
  logic [MEAS_CNT_W-1:0] meas_cnt;

  modport master (
    output req, delay, trigger,
    input  start, stop, cntrl_tdc, busy,
    input  done, timeout, tdc_id, meas_cnt
  );

  modport slave (
    input  req, delay, trigger,
    output start, stop, cntrl_tdc, busy,
    output done, timeout, tdc_id, meas_cnt
  );

endinterface

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer for the async TDC trigger
// followed by a registered rising-edge pulse.
module trig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh   <= '0;
      rise <= 1'b0;
    end else begin
      sh   <= {sh[1:0], trigger};
      rise <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/tdc_meas_seq.sv
// Dual-TDC measurement sequencer: start/stop pulse pair,
// trigger wait with timeout, ping-pong TDC select.
module tdc_meas_seq
  import tdc_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 1000,
  parameter bit PINGPONG = 1'b1
) (
  input logic           clk,
  input logic           rst,
  tdc_meas_seq_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT);

  tdc_seq_state_t        state;
  logic [CNT_W-1:0]      gap_cnt;
  logic [TW-1:0]         to_cnt;
  logic [MEAS_CNT_W-1:0] meas_q;
  logic                  rise;
  logic                  start_q;
  logic                  stop_q;
  logic                  sel_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  to_q;
  logic                  id_q;

  trig_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .trigger (bus.trigger),
    .rise    (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      to_cnt  <= '0;
      meas_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      sel_q   <= TDC_A;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.req) begin
            gap_cnt <= bus.delay;
            busy_q  <= 1'b1;
            state   <= S_ARM;
          end
        end
        S_ARM: begin
          start_q <= 1'b1;
          state   <= S_START;
        end
        S_START: begin
          if (gap_cnt == '0) begin
            stop_q <= 1'b1;
            state  <= S_STOP;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == CNT_W'(1)) begin
            stop_q <= 1'b1;
            state  <= S_STOP;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_STOP: begin
          to_cnt <= '0;
          state  <= S_WAIT_TRIG;
        end
        // Edge is tested first so it wins over a same-cycle expiry.
        S_WAIT_TRIG: begin
          if (rise) begin
            done_q <= 1'b1;
            to_q   <= 1'b0;
            id_q   <= sel_q;
            meas_q <= meas_q + 1'b1;
            state  <= S_DONE;
          end else if (to_cnt == T_LAST) begin
            done_q <= 1'b1;
            to_q   <= 1'b1;
            id_q   <= sel_q;
            state  <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
          if (!to_q) begin
            sel_q <= next_tdc(sel_q, PINGPONG);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.start     = start_q;
  assign bus.stop      = stop_q;
  assign bus.cntrl_tdc = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = to_q;
  assign bus.tdc_id    = id_q;
  assign bus.meas_cnt  = meas_q;

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Randomized bench for tdc_meas_seq: two instances (ping-pong on/off)
// share stimulus and are scored against a cycle-level event model.
module tb_tdc_meas_seq;
  import tdc_pkg::*;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [7:0] delay = '0;
  logic       trigger = 1'b0;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int ovl = 0;
  logic prev_sel0 = 1'b0;

  int m_tdc0 = 0;
  int m_tdc1 = 0;
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  tdc_meas_seq_if #(.CNT_W(8)) bus0 ();
  tdc_meas_seq_if #(.CNT_W(8)) bus1 ();

  assign bus0.req     = req;
  assign bus0.delay   = delay;
  assign bus0.trigger = trigger;
  assign bus1.req     = req;
  assign bus1.delay   = delay;
  assign bus1.trigger = trigger;

  tdc_meas_seq #(.CNT_W(8), .TIMEOUT(TO), .PINGPONG(1'b1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  tdc_meas_seq #(.CNT_W(8), .TIMEOUT(TO), .PINGPONG(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // start/stop overlap, or select moving under a pulse
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.start && bus0.stop) ovl <= ovl + 1;
      if ((bus0.start || bus0.stop) && bus0.cntrl_tdc != prev_sel0)
        ovl <= ovl + 1;
    end
    prev_sel0 <= bus0.cntrl_tdc;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [6:0] flags(input int which);
    if (which == 0)
      return {bus0.start, bus0.stop, bus0.cntrl_tdc, bus0.busy,
              bus0.done, bus0.timeout, bus0.tdc_id};
    return {bus1.start, bus1.stop, bus1.cntrl_tdc, bus1.busy,
            bus1.done, bus1.timeout, bus1.tdc_id};
  endfunction

  // scen: 0 trigger lat cycles after stop, 1 no trigger,
  // 2 trigger already high at request, 3 glitch in GAP then trigger
  task automatic run_meas(input int d, input int scen, input int lat);
    int n, c, s_exp, d_exp, st_c, sp_c, dn_c, n_st, n_sp;
    bit ok, busy_bad;
    logic to_o, to_o1, id0, id1, sel0, sel1, done1;
    logic [15:0] cnt0, cnt1;
    @(negedge clk);
    n = cyc;
    req = 1'b1;
    delay = d[7:0];
    if (scen == 2) trigger = 1'b1;
    s_exp = n + 3 + d;
    ok = (scen == 0 || scen == 3) && lat <= TO - 2;
    d_exp = ok ? s_exp + lat + 4 : s_exp + TO + 2;
    st_c = -1; sp_c = -1; dn_c = -1;
    n_st = 0; n_sp = 0; busy_bad = 1'b0;
    for (int i = 0; i < TO + 300 && dn_c < 0; i++) begin
      @(negedge clk);
      c = cyc;
      if (bus0.start) begin
        n_st++;
        if (st_c < 0) begin
          st_c = c; sel0 = bus0.cntrl_tdc; sel1 = bus1.cntrl_tdc;
        end
      end
      if (bus0.stop) begin
        n_sp++;
        if (sp_c < 0) sp_c = c;
      end
      if (!bus0.busy) busy_bad = 1'b1;
      if (bus0.done) begin
        dn_c = c; to_o = bus0.timeout; to_o1 = bus1.timeout;
        id0 = bus0.tdc_id; id1 = bus1.tdc_id; done1 = bus1.done;
        cnt0 = bus0.meas_cnt; cnt1 = bus1.meas_cnt;
      end
      req = (c == n + 2);
      delay = 8'($urandom);
      if (scen == 3 && c == n + 3) trigger = 1'b1;
      if (scen == 3 && c == n + 4) trigger = 1'b0;
      if (ok && c == s_exp + lat) trigger = 1'b1;
    end
    if (ok) begin
      m_cnt0 = (m_cnt0 + 1) & 16'hFFFF;
      m_cnt1 = (m_cnt1 + 1) & 16'hFFFF;
    end
    check("start_cycle", st_c, n + 2);
    check("stop_cycle", sp_c, s_exp);
    check("pulse_count", n_st * 10 + n_sp, 11);
    check("busy_held", busy_bad, 0);
    check("done_cycle", dn_c, d_exp);
    check("timeout", to_o, !ok);
    check("tdc_id_pp", id0, m_tdc0);
    check("sel_at_start_pp", sel0, m_tdc0);
    check("meas_cnt_pp", cnt0, m_cnt0);
    check("done_nopp", done1, 1);
    check("timeout_nopp", to_o1, !ok);
    check("tdc_id_nopp", id1, m_tdc1);
    check("sel_at_start_nopp", sel1, m_tdc1);
    check("meas_cnt_nopp", cnt1, m_cnt1);
    if (ok) m_tdc0 = m_tdc0 ^ 1;
    @(negedge clk);
    trigger = 1'b0;
    check("busy_after_done", bus0.busy, 0);
    check("done_one_cycle", bus0.done, 0);
  endtask

  task automatic rst_mid(input int off);
    int dn;
    @(negedge clk);
    req = 1'b1;
    delay = 8'd6;
    @(negedge clk);
    req = 1'b0;
    repeat (off - 1) @(negedge clk);
    if (off == 2) check("start_before_rst", bus0.start, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_flags_pp", flags(0), 0);
    check("rst_mid_flags_nopp", flags(1), 0);
    check("rst_mid_cnt_pp", bus0.meas_cnt, 0);
    check("rst_mid_cnt_nopp", bus1.meas_cnt, 0);
    rst = 1'b0;
    m_tdc0 = 0; m_tdc1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    dn = 0;
    repeat (TO + 20) begin
      @(negedge clk);
      if (bus0.done || bus1.done || bus0.start || bus0.busy) dn++;
    end
    check("rst_mid_quiet", dn, 0);
  endtask

  initial begin
    int d, sc, lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_flags_pp", flags(0), 0);
    check("reset_flags_nopp", flags(1), 0);
    check("reset_cnt", bus0.meas_cnt, 0);
    rst = 1'b0;

    run_meas(5, 0, 10);
    run_meas(int'($urandom_range(0, 12)), 0, int'($urandom_range(0, TO - 2)));
    run_meas(int'($urandom_range(0, 12)), 0, int'($urandom_range(0, TO - 2)));
    run_meas(int'($urandom_range(0, 12)), 1, 0);
    run_meas(int'($urandom_range(0, 12)), 2, 0);
    run_meas(int'($urandom_range(3, 12)), 3, int'($urandom_range(0, TO - 2)));
    run_meas(0, 0, int'($urandom_range(0, TO - 2)));
    run_meas(int'($urandom_range(0, 12)), 0, TO - 2);
    run_meas(int'($urandom_range(0, 12)), 0, 0);

    for (int k = 0; k < 16; k++) begin
      sc  = int'($urandom_range(0, 3));
      d   = (sc == 3) ? int'($urandom_range(3, 40)) : int'($urandom_range(0, 40));
      lat = int'($urandom_range(0, TO - 2));
      run_meas(d, sc, lat);
    end

    // trigger level held high across reset release
    trigger = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_tdc0 = 0; m_tdc1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    run_meas(4, 2, 0);

    run_meas(3, 0, 2);
    rst_mid(5);
    run_meas(2, 0, 3);
    rst_mid(2);

    @(negedge clk);
    force dut0.meas_q = 16'hFFFE;
    @(negedge clk);
    release dut0.meas_q;
    @(negedge clk);
    check("preload", bus0.meas_cnt, 16'hFFFE);
    m_cnt0 = 16'hFFFE;
    run_meas(1, 0, 4);
    run_meas(2, 0, 5);

    check("overlap_or_sel_move", ovl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
